pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush/halt sequencer for the 16-bit pipelined CPU (IF, ID, ID/EX, EX1/EX2, MEM, WB).

---
 rtl/pipe_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/halt sequencer: RAW scoreboard, branch flush fan-out and HALT drain.
// Stall/flush outputs are combinational; state, halted and perf counters are registered.
module pipe_hazard_ctrl #(
  parameter int SB_DEPTH  = 4,
  parameter int BR_STAGE  = 2,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_rs1,
  input  logic [3:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [3:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_halt,
  input  logic             branch_taken,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_if,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  localparam int HZ_N = SB_DEPTH - WB_BYPASS;
  localparam int DC_W = $clog2(SB_DEPTH + 1);

  state_t              state_q, state_d;
  logic [DC_W-1:0]     drain_q, drain_d;
  logic [SB_DEPTH-1:0] sb_v;
  logic [3:0]          sb_rd [SB_DEPTH];
  logic                hazard, issue, halt_acc, br_acc;

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HZ_N; i++) begin
      if (sb_v[i] && ((id_use_rs1 && sb_rd[i] == id_rs1) ||
                      (id_use_rs2 && sb_rd[i] == id_rs2)))
        hazard = 1'b1;
    end
    hazard = hazard & id_valid & (state_q == ST_RUN);
  end

  // a taken branch is older than anything in ID, so it wins over hazard and halt
  assign br_acc   = branch_taken & (state_q != ST_HALTED);
  assign issue    = id_valid & ~hazard & ~branch_taken & (state_q == ST_RUN);
  assign halt_acc = issue & id_halt;

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_if  = br_acc;
    flush_id  = br_acc;
    flush_ex  = br_acc;
    if (!br_acc && (hazard || state_q != ST_RUN)) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ST_RUN: begin
        if (halt_acc) begin
          state_d = ST_DRAIN;
          drain_d = DC_W'(SB_DEPTH);
        end
      end
      ST_DRAIN: begin
        if (br_acc) begin
          state_d = ST_RUN;
          drain_d = '0;
        end else if (drain_q == DC_W'(1)) begin
          state_d = ST_HALTED;
          drain_d = '0;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      ST_HALTED: ;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      drain_q      <= '0;
      halted       <= 1'b0;
      sb_v         <= '0;
      stall_cycles <= '0;
      flush_events <= '0;
      for (int i = 0; i < SB_DEPTH; i++) sb_rd[i] <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      halted  <= (state_d == ST_HALTED);
      // HALT travels down the pipe as a bubble, never as a write
      sb_v[0]  <= issue & id_reg_write & ~id_halt;
      sb_rd[0] <= id_rd;
      for (int i = 1; i < SB_DEPTH; i++) begin
        sb_v[i]  <= sb_v[i-1] & ~(br_acc && (i - 1) < BR_STAGE);
        sb_rd[i] <= sb_rd[i-1];
      end
      if (hazard && !br_acc && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if (br_acc && flush_events != '1)
        flush_events <= flush_events + 1'b1;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector tables, hand sequences and a randomized run against
// an age-based model of in-flight writes; a second instance covers WB_BYPASS=0 and saturation.
module tb_pipe_hazard_ctrl;

  localparam int DEPTH = 4;
  localparam int BRS   = 2;
  localparam int HZ_A  = 3;
  localparam int CMAX  = 65535;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_halt, branch_taken;
  logic [3:0] id_rs1, id_rs2, id_rd;

  logic a_stall_if, a_stall_id, a_bubble_ex, a_flush_if, a_flush_id, a_flush_ex, a_halted;
  logic [1:0] a_state;
  logic [15:0] a_stall_cycles, a_flush_events;
  logic b_stall_if, b_stall_id, b_bubble_ex, b_flush_if, b_flush_id, b_flush_ex, b_halted;
  logic [1:0] b_state;
  logic [7:0] b_stall_cycles, b_flush_events;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.SB_DEPTH(4), .BR_STAGE(2), .WB_BYPASS(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_halt(id_halt), .branch_taken(branch_taken),
    .stall_if(a_stall_if), .stall_id(a_stall_id), .bubble_ex(a_bubble_ex),
    .flush_if(a_flush_if), .flush_id(a_flush_id), .flush_ex(a_flush_ex),
    .halted(a_halted), .state(a_state),
    .stall_cycles(a_stall_cycles), .flush_events(a_flush_events));

  pipe_hazard_ctrl #(.SB_DEPTH(4), .BR_STAGE(2), .WB_BYPASS(0), .CNT_W(8)) u_nb (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_halt(id_halt), .branch_taken(branch_taken),
    .stall_if(b_stall_if), .stall_id(b_stall_id), .bubble_ex(b_bubble_ex),
    .flush_if(b_flush_if), .flush_id(b_flush_id), .flush_ex(b_flush_ex),
    .halted(b_halted), .state(b_state),
    .stall_cycles(b_stall_cycles), .flush_events(b_flush_events));

  typedef struct {
    logic v; logic [3:0] rs1; logic [3:0] rs2; logic u1; logic u2;
    logic [3:0] rd; logic rw; logic h; logic b;
  } in_t;

  typedef struct {
    in_t i; logic e_stall; logic e_flush; logic [1:0] e_state;
  } vec_t;

  typedef struct { logic [3:0] rd; int t; } wr_t;

  int n_cmp = 0;
  int n_bad = 0;

  // model: writes remembered with the cycle they issued; age decides pipe position
  wr_t wq[$];
  int now = 0;
  int halt_t = -1;
  int m_stall = 0;
  int m_flush = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(logic v, logic [3:0] rs1, logic u1, logic [3:0] rd,
                             logic rw, logic h, logic b);
    in_t x;
    x.v = v; x.rs1 = rs1; x.rs2 = 4'd0; x.u1 = u1; x.u2 = 1'b0;
    x.rd = rd; x.rw = rw; x.h = h; x.b = b;
    return x;
  endfunction

  task automatic apply(input in_t x);
    id_valid = x.v; id_rs1 = x.rs1; id_rs2 = x.rs2; id_use_rs1 = x.u1; id_use_rs2 = x.u2;
    id_rd = x.rd; id_reg_write = x.rw; id_halt = x.h; branch_taken = x.b;
  endtask

  function automatic int m_mode();
    if (halt_t < 0) return 0;
    if (now - halt_t <= DEPTH) return 1;
    return 2;
  endfunction

  function automatic bit m_haz();
    if (!id_valid || m_mode() != 0) return 1'b0;
    foreach (wq[k]) begin
      int age;
      age = now - wq[k].t;
      if (age >= 1 && age <= HZ_A &&
          ((id_use_rs1 && wq[k].rd == id_rs1) || (id_use_rs2 && wq[k].rd == id_rs2)))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic settle();
    int mode;
    bit haz, br, stl;
    logic [8:0] exp_v, act_v;
    #1;
    mode = m_mode();
    haz  = m_haz();
    br   = branch_taken && mode != 2;
    stl  = !br && (haz || mode != 0);
    exp_v = {stl, stl, stl, br, br, br, (mode == 2), 2'(mode)};
    act_v = {a_stall_if, a_stall_id, a_bubble_ex, a_flush_if, a_flush_id, a_flush_ex,
             a_halted, a_state};
    chk("model_outputs", 32'(act_v), 32'(exp_v));
    chk("model_stall_cycles", 32'(a_stall_cycles), 32'(m_stall));
    chk("model_flush_events", 32'(a_flush_events), 32'(m_flush));
  endtask

  task automatic tick();
    int mode;
    bit haz, br, iss;
    mode = m_mode();
    haz  = m_haz();
    br   = branch_taken && mode != 2;
    @(posedge clk);
    if (rst) begin
      wq.delete();
      halt_t = -1; m_stall = 0; m_flush = 0;
    end else begin
      if (br)
        for (int k = wq.size() - 1; k >= 0; k--)
          if (now - wq[k].t <= BRS) wq.delete(k);
      iss = id_valid && !haz && !branch_taken && mode == 0;
      if (iss && id_halt) halt_t = now;
      else if (iss && id_reg_write) wq.push_back('{id_rd, now});
      if (br && mode == 1) halt_t = -1;
      if (haz && !br && m_stall < CMAX) m_stall++;
      if (br && m_flush < CMAX) m_flush++;
    end
    now++;
    for (int k = wq.size() - 1; k >= 0; k--)
      if (now - wq[k].t > DEPTH) wq.delete(k);
    @(negedge clk);
  endtask

  task automatic step(input in_t x);
    apply(x); settle(); tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(mk(0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
  endtask

  task automatic run_table(input string name, input vec_t t[], input int n);
    for (int k = 0; k < n; k++) begin
      apply(t[k].i);
      settle();
      chk({name, "_stall_id"}, 32'(a_stall_id), 32'(t[k].e_stall));
      chk({name, "_stall_if"}, 32'(a_stall_if), 32'(t[k].e_stall));
      chk({name, "_flush_ex"}, 32'(a_flush_ex), 32'(t[k].e_flush));
      chk({name, "_state"}, 32'(a_state), 32'(t[k].e_state));
      tick();
    end
  endtask

  vec_t t1[], t3[];
  in_t idle, x;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0);
    apply(idle);
    @(negedge clk);
    do_reset();

    // reset values
    apply(idle); #1;
    chk("reset_outputs_a", 32'({a_stall_if, a_stall_id, a_bubble_ex, a_flush_if, a_flush_id,
        a_flush_ex, a_halted, a_state}), 32'd0);
    chk("reset_counters_a", 32'({a_stall_cycles, a_flush_events}), 32'd0);
    chk("reset_outputs_b", 32'({b_stall_if, b_flush_if, b_halted, b_state, b_stall_cycles}), 32'd0);
    @(negedge clk);

    // RAW stall: 3 cycles, issues on the 4th
    t1 = new[6];
    t1[0] = '{mk(1, 2, 1, 1, 1, 0, 0), 1'b0, 1'b0, 2'd0};
    t1[1] = '{mk(1, 1, 1, 3, 1, 0, 0), 1'b1, 1'b0, 2'd0};
    t1[2] = '{mk(1, 1, 1, 3, 1, 0, 0), 1'b1, 1'b0, 2'd0};
    t1[3] = '{mk(1, 1, 1, 3, 1, 0, 0), 1'b1, 1'b0, 2'd0};
    t1[4] = '{mk(1, 1, 1, 3, 1, 0, 0), 1'b0, 1'b0, 2'd0};
    t1[5] = '{idle, 1'b0, 1'b0, 2'd0};
    run_table("raw", t1, 6);
    chk("raw_stall_cycles", 32'(a_stall_cycles), 32'd3);

    // branch kills young r2 producer, old one retires
    do_reset();
    t3 = new[6];
    t3[0] = '{mk(1, 0, 0, 2, 1, 0, 0), 1'b0, 1'b0, 2'd0};
    t3[1] = '{idle, 1'b0, 1'b0, 2'd0};
    t3[2] = '{idle, 1'b0, 1'b0, 2'd0};
    t3[3] = '{mk(1, 0, 0, 2, 1, 0, 0), 1'b0, 1'b0, 2'd0};
    t3[4] = '{mk(1, 2, 1, 5, 1, 0, 1), 1'b0, 1'b1, 2'd0};
    t3[5] = '{mk(1, 2, 1, 5, 1, 0, 0), 1'b0, 1'b0, 2'd0};
    run_table("branch", t3, 6);
    chk("branch_flush_events", 32'(a_flush_events), 32'd1);

    // WB bypass vs none: producer only in the last entry
    do_reset();
    step(mk(1, 0, 0, 7, 1, 0, 0));
    step(idle); step(idle); step(idle);
    apply(mk(1, 7, 1, 8, 1, 0, 0)); settle();
    chk("bypass_no_stall", 32'(a_stall_id), 32'd0);
    chk("nobypass_stall", 32'(b_stall_id), 32'd1);
    tick();
    apply(mk(1, 7, 1, 8, 1, 0, 0)); settle();
    chk("nobypass_release", 32'(b_stall_id), 32'd0);
    chk("nobypass_stall_cycles", 32'(b_stall_cycles), 32'd1);
    tick();

    // HALT drains 4 cycles then halts; branch ignored in HALTED
    do_reset();
    apply(mk(1, 0, 0, 0, 0, 1, 0)); settle();
    chk("halt_accept_nostall", 32'(a_stall_if), 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      apply(idle); settle();
      chk("drain_state", 32'({a_state, a_halted, a_stall_if}), 32'({2'b01, 1'b0, 1'b1}));
      tick();
    end
    apply(mk(0, 0, 0, 0, 0, 0, 1)); settle();
    chk("halted_state", 32'({a_state, a_halted, a_stall_if, a_flush_if}),
        32'({2'b10, 1'b1, 1'b1, 1'b0}));
    tick();
    apply(idle); settle();
    chk("halted_sticky", 32'({a_state, a_halted}), 32'({2'b10, 1'b1}));
    tick();

    // branch on 2nd DRAIN cycle returns to RUN
    do_reset();
    step(mk(1, 0, 0, 0, 0, 1, 0));
    apply(idle); settle();
    chk("drain1_state", 32'(a_state), 32'd1);
    tick();
    apply(mk(0, 0, 0, 0, 0, 0, 1)); settle();
    chk("drain_branch_flush", 32'({a_flush_if, a_flush_id, a_flush_ex, a_stall_if}), 32'b1110);
    tick();
    apply(idle); settle();
    chk("drain_branch_run", 32'({a_state, a_halted, a_stall_if}), 32'd0);
    chk("drain_branch_count", 32'(a_flush_events), 32'd1);
    tick();

    // reset mid-DRAIN with a producer still tracked
    do_reset();
    step(mk(1, 0, 0, 5, 1, 0, 0));
    apply(mk(1, 5, 1, 6, 1, 0, 0)); settle();
    chk("pre_rst_stall", 32'(a_stall_id), 32'd1);
    tick();
    step(mk(1, 0, 0, 0, 0, 1, 0));
    rst = 1'b1;
    apply(mk(1, 5, 1, 6, 1, 1, 1)); settle();
    chk("pre_rst_state", 32'(a_state), 32'd1);
    tick();
    rst = 1'b0;
    apply(mk(1, 5, 1, 6, 1, 0, 0)); settle();
    chk("post_rst_outputs", 32'({a_stall_if, a_stall_id, a_bubble_ex, a_flush_if, a_halted,
        a_state}), 32'd0);
    chk("post_rst_counters", 32'({a_stall_cycles, a_flush_events}), 32'd0);
    tick();

    // saturation on the narrow-counter instance
    do_reset();
    for (int k = 0; k < 10; k++) step(mk(1, 1, 1, 1, 1, 0, 0));
    chk("nb_stall_count_10", 32'(b_stall_cycles), 32'd8);
    for (int k = 0; k < 400; k++) step(mk(1, 1, 1, 1, 1, 0, 0));
    chk("nb_stall_saturated", 32'(b_stall_cycles), 32'hFF);

    // randomized run against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      x.v   = ($urandom_range(0, 7) != 0);
      x.rs1 = 4'($urandom_range(0, 3));
      x.rs2 = 4'($urandom_range(0, 3));
      x.u1  = 1'($urandom);
      x.u2  = 1'($urandom);
      x.rd  = 4'($urandom_range(0, 3));
      x.rw  = 1'($urandom);
      x.h   = ($urandom_range(0, 15) == 0);
      x.b   = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 199) == 0) || (m_mode() == 2 && $urandom_range(0, 5) == 0);
      step(x);
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
